// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and 74LS85-style cascade codes for the sequential comparator.
package cmp_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [2:0] CAS_GT = 3'b100;
    localparam logic [2:0] CAS_LT = 3'b010;
    localparam logic [2:0] CAS_EQ = 3'b001;
    // Equal-nibble pass-through of the cascade, including the 74LS85 oddities for 110/000.
    function automatic logic [2:0] cas_resolve(input logic [2:0] c);
        return c[0] ? CAS_EQ : (c[2] & c[1]) ? 3'b000 : (!c[2] & !c[1]) ? 3'b110 : c;
    endfunction
endpackage

// File: rtl/nibble_cascade_cmp.sv
// nibble_cascade_cmp: one 4-bit magnitude compare stage with cascade input.
module nibble_cascade_cmp
    import cmp_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] cas_in,
    output logic [2:0] cas_out
);
    assign cas_out = (a > b) ? CAS_GT : (a < b) ? CAS_LT : cas_resolve(cas_in);
endmodule

// File: rtl/cascade_compare_sequencer.sv
// cascade_compare_sequencer: walks operands one nibble per cycle, LSB first,
// chaining a single cascade compare stage through a registered carry.
module cascade_compare_sequencer
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cas_gt_i,
    input  logic             cas_lt_i,
    input  logic             cas_eq_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    state_t state, state_nx;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0] carry, nib_res;
    logic last, accept;

    nibble_cascade_cmp u_nib (
        .a      (a_sh[3:0]),
        .b      (b_sh[3:0]),
        .cas_in (carry),
        .cas_out(nib_res)
    );

    assign last = count == CNT_W'(NIBBLES - 1);
    assign accept = state == IDLE && in_valid && !clear;

    always_comb begin
        state_nx = state;
        state_nx = clear                         ? IDLE :
                   (state == IDLE && in_valid)   ? RUN  :
                   (state == RUN && last)        ? DONE :
                   (state == DONE && out_ready)  ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= '0;
            count <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= {cas_gt_i, cas_lt_i, cas_eq_i};
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            carry <= nib_res;
            count <= count + 1'b1;
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign {o_gt, o_lt, o_eq} = out_valid ? carry : 3'b000;
endmodule

// File: tb/tb_cascade_compare_sequencer.sv
// tb_cascade_compare_sequencer: directed and randomized checks against a transaction-level model.
module tb_cascade_compare_sequencer;
    logic clk = 0, rst_n = 0;
    logic clear = 0, in_valid = 0, out_ready = 0;
    logic [15:0] a = 0, b = 0;
    logic [2:0] cas = 0;
    logic in_ready, out_valid, o_gt, o_lt, o_eq;
    logic in_valid4 = 0, out_ready4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic [2:0] cas4 = 0;
    logic in_ready4, out_valid4, o_gt4, o_lt4, o_eq4;
    int n_cmp = 0, n_bad = 0;

    cascade_compare_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cas_gt_i(cas[2]), .cas_lt_i(cas[1]), .cas_eq_i(cas[0]),
        .out_valid(out_valid), .out_ready(out_ready), .o_gt(o_gt), .o_lt(o_lt), .o_eq(o_eq)
    );

    cascade_compare_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cas_gt_i(cas4[2]), .cas_lt_i(cas4[1]), .cas_eq_i(cas4[0]),
        .out_valid(out_valid4), .out_ready(out_ready4), .o_gt(o_gt4), .o_lt(o_lt4), .o_eq(o_eq4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operand view: magnitude decides when operands differ; otherwise the
    // cascade code passes through NIBBLES equal stages (110/000 toggle each stage).
    function automatic logic [2:0] expect_res(input logic [31:0] x, input logic [31:0] y,
                                              input logic [2:0] c, input int nib);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        if (c[0]) return 3'b001;
        if (c == 3'b100 || c == 3'b010) return c;
        return (nib % 2 == 0) ? c : (~c & 3'b110);
    endfunction

    bit m_busy = 0, m_valid = 0;
    int m_left = 0;
    logic [2:0] m_res = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_left = 0;
        end else if (clear) begin
            m_busy = 0; m_valid = 0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid = 0; m_busy = 0; end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_valid = 1;
        end else if (in_valid) begin
            m_busy = 1; m_left = 4; m_res = expect_res({16'h0, a}, {16'h0, b}, cas, 4);
        end
    end

    always @(negedge clk)
        check("cycle", {27'h0, in_ready, out_valid, o_gt, o_lt, o_eq},
              {27'h0, !m_busy, m_valid, m_valid ? m_res : 3'b000});

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic [2:0] c,
                        input int hold, input logic [2:0] exp);
        int lat;
        @(posedge clk); #1;
        a = x; b = y; cas = c; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; a = 16'($urandom); b = 16'($urandom); cas = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency16", lat, 4);
        check("result16", {29'h0, o_gt, o_lt, o_eq}, {29'h0, exp});
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold16", {27'h0, in_ready, out_valid, o_gt, o_lt, o_eq}, {27'h0, 2'b01, exp});
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("handoff16", {30'h0, in_ready, out_valid}, 32'h2);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic [2:0] c,
                       input logic [2:0] exp);
        int lat;
        @(posedge clk); #1;
        a4 = x; b4 = y; cas4 = c; in_valid4 = 1;
        @(posedge clk); #1;
        in_valid4 = 0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency4", lat, 1);
        check("result4", {29'h0, o_gt4, o_lt4, o_eq4}, {29'h0, exp});
        out_ready4 = 1;
        @(posedge clk); #1;
        out_ready4 = 0;
        check("handoff4", {30'h0, in_ready4, out_valid4}, 32'h2);
    endtask

    initial begin
        bit seen;
        int lat;
        repeat (2) @(posedge clk);
        #1;
        check("reset16", {27'h0, in_ready, out_valid, o_gt, o_lt, o_eq}, 32'h10);
        check("reset4", {27'h0, in_ready4, out_valid4, o_gt4, o_lt4, o_eq4}, 32'h10);
        rst_n = 1;

        op16(16'h1234, 16'h1234, 3'b001, 0, 3'b001);
        op16(16'h8000, 16'h7FFF, 3'b001, 0, 3'b100);
        op16(16'h0001, 16'h0002, 3'b100, 0, 3'b010);
        op16(16'h0000, 16'h0000, 3'b110, 0, 3'b110);
        op16(16'h0000, 16'h0000, 3'b000, 0, 3'b000);
        op16(16'hBEEF, 16'hBEEF, 3'b010, 5, 3'b010);
        op16(16'h5A5A, 16'h5A5B, 3'b111, 2, 3'b010);

        op4(4'hA, 4'h5, 3'b001, 3'b100);
        op4(4'h0, 4'h0, 3'b110, 3'b000);
        op4(4'h0, 4'h0, 3'b000, 3'b110);
        op4(4'h3, 4'h3, 3'b101, 3'b001);

        // clear during the second RUN cycle
        @(posedge clk); #1;
        a = 16'h0F00; b = 16'h00F0; cas = 3'b001; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        check("clear_idle", {30'h0, in_ready, out_valid}, 32'h2);
        seen = 0;
        repeat (6) begin @(posedge clk); #1; seen |= out_valid; end
        check("clear_no_valid", {31'h0, seen}, 0);

        // async reset while a result waits in DONE
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000; cas = 3'b001; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("pre_reset_done", {28'h0, out_valid, o_gt, o_lt, o_eq}, 32'hC);
        rst_n = 0;
        #1;
        check("async_reset", {27'h0, in_ready, out_valid, o_gt, o_lt, o_eq}, 32'h10);
        @(posedge clk); #1;
        rst_n = 1;

        repeat (400) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (16'hF << (4 * $urandom_range(0, 3)));
                default: b = 16'($urandom);
            endcase
            cas = 3'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            clear = $urandom_range(0, 31) == 0;
        end
        @(posedge clk); #1;
        in_valid = 0; clear = 0; out_ready = 1;
        repeat (8) @(posedge clk);
        #1;
        check("drained", {30'h0, in_ready, out_valid}, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
